// File: rtl/regs_file_pkg.sv
// Shared constants for the register file: default widths, register count, zero-register index.
// No logic of its own; imported by regs_file.
// No flow control involved.
package regs_file_pkg;

  // Default register width in bits.
  localparam int DEF_DATA_W = 32;
  // Default register index width.
  localparam int DEF_ADDR_W = 5;
  // Number of registers with the default index width.
  localparam int REG_COUNT  = 1 << DEF_ADDR_W;
  // Hard-wired zero register; reads 0, writes are dropped.
  localparam int ZERO_REG   = 0;

endpackage

// File: rtl/regs_file.sv
// Register file, 2 combinational read ports, 1 synchronous write port; r0 hard-wired to 0.
// Read latency 0 cycles, write visible the cycle after its edge; optional write-through via REGS_FILE_BYPASS_EN.
// No backpressure: a write is accepted on every edge it is presented (rst has priority).
module regs_file
  import regs_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rgr1,
  input  logic [ADDR_W-1:0] rgr2,
  input  logic              write,
  input  logic [ADDR_W-1:0] rgw1,
  input  logic [DATA_W-1:0] rgw1data,
  output logic [DATA_W-1:0] rg1data,
  output logic [DATA_W-1:0] rg2data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_en;

  // Qualified write: reset wins, and index 0 is never a write target.
  assign wr_en = write && !rst && (rgw1 != ZERO_IDX);

  // Storage: clear everything on reset, otherwise update only the addressed register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[rgw1] <= rgw1data;
    end
  end

  // Read muxes: r0 forced to 0 so it is clean even before the first reset.
  always_comb begin
    rg1data = (rgr1 == ZERO_IDX) ? '0 : regs[rgr1];
    rg2data = (rgr2 == ZERO_IDX) ? '0 : regs[rgr2];
`ifdef REGS_FILE_BYPASS_EN
    // Forward the in-flight write so a same-cycle read sees the new value.
    if (wr_en && (rgr1 == rgw1)) rg1data = rgw1data;
    if (wr_en && (rgr2 == rgw1)) rg2data = rgw1data;
`endif
  end

endmodule

// File: tb/tb_regs_file.sv
// Self-checking bench for regs_file: directed scenarios plus randomized traffic against an array model.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Honours REGS_FILE_BYPASS_EN for same-cycle read expectations.
module tb_regs_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          write;
  logic [AW-1:0] rgr1, rgr2, rgw1;
  logic [DW-1:0] rgw1data;
  logic [DW-1:0] rg1data, rg2data;

  int checks = 0;
  int errors = 0;

  // Reference model: plain array of register values.
  logic [DW-1:0] model [N];

  always #5 clk = ~clk;

  regs_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rgr1(rgr1), .rgr2(rgr2), .write(write),
    .rgw1(rgw1), .rgw1data(rgw1data), .rg1data(rg1data), .rg2data(rg2data)
  );

  // Expected read value for an index given the model and the current inputs.
  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = (a == 0) ? '0 : model[a];
`ifdef REGS_FILE_BYPASS_EN
    if (write && !rst && rgw1 != 0 && a == rgw1) v = rgw1data;
`endif
    return v;
  endfunction

  // Apply one clock edge to the model with the current inputs, then move past the edge.
  task automatic step();
    if (rst) begin
      for (int i = 0; i < N; i++) model[i] = '0;
    end else if (write && rgw1 != 0) begin
      model[rgw1] = rgw1data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; write = 1'b1; rgw1 = 5'd3; rgw1data = 32'hCAFEF00D;
    step();
    rst = 1'b0; write = 1'b0;
    for (int i = 0; i < N; i++) begin
      rgr1 = AW'(i);
      rgr2 = AW'(N - 1 - i);
      #1;
      checks++;
      if (rg1data !== 32'h0) begin
        errors++;
        $display("FAIL reset_rd1 idx=%0d got=%h exp=00000000", i, rg1data);
      end
      checks++;
      if (rg2data !== 32'h0) begin
        errors++;
        $display("FAIL reset_rd2 idx=%0d got=%h exp=00000000", N - 1 - i, rg2data);
      end
    end
  endtask

  task automatic test_write_seq();
    logic [DW-1:0] vals [6];
    vals = '{32'd5, 32'd2, 32'd2, 32'd4, 32'd7, 32'd9};
    for (int i = 0; i < 6; i++) begin
      write = 1'b1; rgw1 = AW'(20 + i); rgw1data = vals[i];
      step();
    end
    write = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rgr1 = AW'(20 + i);
      rgr2 = AW'(25 - i);
      #1;
      checks++;
      if (rg1data !== vals[i]) begin
        errors++;
        $display("FAIL write_seq_rd1 idx=%0d got=%h exp=%h", 20 + i, rg1data, vals[i]);
      end
      checks++;
      if (rg2data !== vals[5 - i]) begin
        errors++;
        $display("FAIL write_seq_rd2 idx=%0d got=%h exp=%h", 25 - i, rg2data, vals[5 - i]);
      end
    end
  endtask

  task automatic test_accumulate();
    logic [DW-1:0] sum;
    write = 1'b1; rgw1 = 5'd31; rgw1data = '0;
    step();
    for (int i = 0; i < 6; i++) begin
      write = 1'b0; rgr1 = 5'd31; rgr2 = AW'(20 + i);
      #1;
      checks++;
      if (rg1data !== model[31]) begin
        errors++;
        $display("FAIL accum_partial step=%0d got=%h exp=%h", i, rg1data, model[31]);
      end
      sum = rg1data + rg2data;
      write = 1'b1; rgw1 = 5'd31; rgw1data = sum;
      step();
    end
    write = 1'b0; rgr1 = 5'd31; rgr2 = 5'd31;
    #1;
    checks++;
    if (rg1data !== 32'h1D) begin
      errors++;
      $display("FAIL accum_total got=%h exp=0000001d", rg1data);
    end
  endtask

  task automatic test_zero_reg();
    write = 1'b1; rgw1 = 5'd0; rgw1data = 32'hDEADBEEF; rgr1 = 5'd0; rgr2 = 5'd0;
    #1;
    checks++;
    if (rg1data !== 32'h0) begin
      errors++;
      $display("FAIL zero_reg_pre got=%h exp=00000000", rg1data);
    end
    step();
    write = 1'b0;
    #1;
    checks++;
    if (rg1data !== 32'h0) begin
      errors++;
      $display("FAIL zero_reg_post got=%h exp=00000000", rg1data);
    end
    checks++;
    if (rg2data !== 32'h0) begin
      errors++;
      $display("FAIL zero_reg_post_rd2 got=%h exp=00000000", rg2data);
    end
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] pre;
`ifdef REGS_FILE_BYPASS_EN
    pre = 32'h12345678;
`else
    pre = 32'h0;
`endif
    rgr1 = 5'd7; rgr2 = 5'd7; write = 1'b1; rgw1 = 5'd7; rgw1data = 32'h12345678;
    #1;
    checks++;
    if (rg1data !== pre) begin
      errors++;
      $display("FAIL same_cycle_pre_rd1 got=%h exp=%h", rg1data, pre);
    end
    checks++;
    if (rg2data !== pre) begin
      errors++;
      $display("FAIL same_cycle_pre_rd2 got=%h exp=%h", rg2data, pre);
    end
    step();
    write = 1'b0;
    #1;
    checks++;
    if (rg1data !== 32'h12345678) begin
      errors++;
      $display("FAIL same_cycle_post_rd1 got=%h exp=12345678", rg1data);
    end
    checks++;
    if (rg2data !== 32'h12345678) begin
      errors++;
      $display("FAIL same_cycle_post_rd2 got=%h exp=12345678", rg2data);
    end
  endtask

  task automatic test_reset_priority();
    write = 1'b1; rgw1 = 5'd10; rgw1data = 32'h55;
    step();
    rst = 1'b1; write = 1'b1; rgw1 = 5'd10; rgw1data = 32'hFFFFFFFF;
    step();
    rst = 1'b0; write = 1'b0; rgr1 = 5'd10; rgr2 = 5'd7;
    #1;
    checks++;
    if (rg1data !== 32'h0) begin
      errors++;
      $display("FAIL rst_priority_r10 got=%h exp=00000000", rg1data);
    end
    checks++;
    if (rg2data !== 32'h0) begin
      errors++;
      $display("FAIL rst_priority_r7 got=%h exp=00000000", rg2data);
    end
    // First edge after reset must accept a write again.
    write = 1'b1; rgw1 = 5'd10; rgw1data = 32'hA5A5A5A5;
    step();
    write = 1'b0;
    #1;
    checks++;
    if (rg1data !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL rst_resume got=%h exp=a5a5a5a5", rg1data);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] e1, e2;
    for (int it = 0; it < 400; it++) begin
      rst      = ($urandom_range(31) == 0);
      write    = 1'($urandom_range(1));
      rgw1     = AW'($urandom);
      rgw1data = $urandom;
      rgr1     = ($urandom_range(3) == 0) ? rgw1 : AW'($urandom);
      rgr2     = ($urandom_range(3) == 0) ? rgr1 : AW'($urandom);
      #1;
      e1 = exp_read(rgr1);
      e2 = exp_read(rgr2);
      checks++;
      if (rg1data !== e1) begin
        errors++;
        $display("FAIL random_rd1 it=%0d idx=%0d got=%h exp=%h", it, rgr1, rg1data, e1);
      end
      checks++;
      if (rg2data !== e2) begin
        errors++;
        $display("FAIL random_rd2 it=%0d idx=%0d got=%h exp=%h", it, rgr2, rg2data, e2);
      end
      step();
    end
    rst = 1'b0; write = 1'b0;
  endtask

  initial begin
    rst = 1'b1; write = 1'b0; rgr1 = '0; rgr2 = '0; rgw1 = '0; rgw1data = '0;
    for (int i = 0; i < N; i++) model[i] = '0;
    #1;
    step();
    step();
    test_reset();
    test_write_seq();
    test_accumulate();
    test_zero_reg();
    test_same_cycle();
    test_reset_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
